mp_csa_accum: RTL and testbench



---
 rtl/mpacc_pkg.sv | 31 +++
 rtl/mp_csa_row.sv | 20 ++
 rtl/mp_csa_accum.sv | 214 +++++++++++++++++++++
 tb/tb_mp_csa_accum.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpacc_pkg.sv
`default_nettype none
// ============================================================================
// mpacc_pkg : command/state encodings and chunk sizing helpers for mp_csa_accum
// Rev 1.0
// ============================================================================
package mpacc_pkg;

  localparam logic [1:0] OP_CLEAR     = 2'd0;
  localparam logic [1:0] OP_ACC       = 2'd1;
  localparam logic [1:0] OP_ACC_SHIFT = 2'd2;
  localparam logic [1:0] OP_RESOLVE   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_SUB  = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  function automatic int nchunk(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

  function automatic int slice_width(input int width, input int chunk, input int k);
    int lo;
    lo = k * chunk;
    return ((width - lo) < chunk) ? (width - lo) : chunk;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mp_csa_row.sv
`default_nettype none
// ============================================================================
// mp_csa_row : WIDTH-wide 3:2 compressor (bitwise sum and majority)
// Rev 1.0
// ============================================================================
module mp_csa_row #(
  parameter int WIDTH = 514
) (
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] m
);

  assign t = s ^ c ^ a;
  assign m = (s & c) | (s & a) | (c & a);

endmodule
`default_nettype wire

// File: rtl/mp_csa_accum.sv
`default_nettype none
// ============================================================================
// mp_csa_accum : carry-save accumulator with chunked resolve; optional final
//                modulus subtraction enabled by MPACC_CONDSUB_EN
// Rev 1.0
// ============================================================================
module mp_csa_accum
  import mpacc_pkg::*;
#(
  parameter int WIDTH = 514,
  parameter int CHUNK = 103
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] modulus,
  output logic             acc_lsb,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_sub,
  output logic             busy
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int PW     = NCHUNK * CHUNK;
  localparam int TOPW   = slice_width(WIDTH, CHUNK, NCHUNK - 1);
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0]    LAST     = CW'(NCHUNK - 1);
  localparam logic [CHUNK-1:0] TOP_MASK = {CHUNK{1'b1}} >> (CHUNK - TOPW);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d, c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cin_q, cin_d;
  logic [PW-1:0]    x_q, x_d, y_q, y_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_sub_q, res_sub_d;

  logic [WIDTH-1:0] row_t, row_m;
  logic [CHUNK:0]   w_sum;
  logic [CHUNK-1:0] w_add_chunk;
  logic [WIDTH-1:0] w_result;
  logic             w_no_borrow;

  mp_csa_row #(.WIDTH(WIDTH)) u_row (
    .s (s_q),
    .c (c_q),
    .a (in_a),
    .t (row_t),
    .m (row_m)
  );

  // Operand slices are streamed out of x/y from the LSB end; results enter at the top.
  function automatic logic [PW-1:0] shift_in(input logic [PW-1:0] v, input logic [CHUNK-1:0] ch);
    return (v >> CHUNK) | (PW'(ch) << (PW - CHUNK));
  endfunction

  assign w_sum       = {1'b0, x_q[CHUNK-1:0]} + {1'b0, y_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, cin_q};
  // Padding above WIDTH is cleared so R sits zero-extended in x for the subtract pass.
  assign w_add_chunk = (cnt_q == LAST) ? (w_sum[CHUNK-1:0] & TOP_MASK) : w_sum[CHUNK-1:0];

`ifdef MPACC_CONDSUB_EN
  logic [WIDTH-1:0] m_q, m_d;
  logic [PW-1:0]    dif_q, dif_d;

  // The borrow-free flag is the carry out of bit WIDTH-1, wherever the top slice ends.
  assign w_no_borrow = 1'(({cin_q, dif_q} >> WIDTH));
  assign w_result    = w_no_borrow ? dif_q[WIDTH-1:0] : x_q[WIDTH-1:0];
`else
  logic unused_modulus;

  assign unused_modulus = ^modulus;
  assign w_no_borrow    = 1'b0;
  assign w_result       = x_q[WIDTH-1:0];
`endif

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    c_d         = c_q;
    cnt_d       = cnt_q;
    cin_d       = cin_q;
    x_d         = x_q;
    y_d         = y_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_sub_d   = res_sub_q;
`ifdef MPACC_CONDSUB_EN
    m_d         = m_q;
    dif_d       = dif_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_CLEAR: begin
              s_d = '0;
              c_d = '0;
            end
            OP_ACC: begin
              s_d = row_t;
              c_d = {row_m[WIDTH-2:0], 1'b0};
            end
            OP_ACC_SHIFT: begin
              s_d = {1'b0, row_t[WIDTH-1:1]};
              c_d = row_m;
            end
            default: begin
              state_d = ST_ADD;
              x_d     = PW'(s_q);
              y_d     = PW'(c_q);
              cnt_d   = '0;
              cin_d   = 1'b0;
`ifdef MPACC_CONDSUB_EN
              m_d     = modulus;
`endif
            end
          endcase
        end
      end
      ST_ADD: begin
        x_d   = shift_in(x_q, w_add_chunk);
        y_d   = y_q >> CHUNK;
        cin_d = w_sum[CHUNK];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
`ifdef MPACC_CONDSUB_EN
          state_d = ST_SUB;
          y_d     = PW'(~m_q);
          cin_d   = 1'b1;
`else
          state_d = ST_OUT;
`endif
        end
      end
`ifdef MPACC_CONDSUB_EN
      ST_SUB: begin
        // x rotates so R is back in place once every slice has been consumed.
        x_d   = (x_q >> CHUNK) | (x_q << (PW - CHUNK));
        y_d   = y_q >> CHUNK;
        dif_d = shift_in(dif_q, w_sum[CHUNK-1:0]);
        cin_d = w_sum[CHUNK];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = ST_OUT;
        end
      end
`endif
      ST_OUT: begin
        if (!res_valid_q) begin
          res_valid_d = 1'b1;
          res_data_d  = w_result;
          res_sub_d   = w_no_borrow;
          s_d         = w_result;
          c_d         = '0;
        end else if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      s_q         <= '0;
      c_q         <= '0;
      cnt_q       <= '0;
      cin_q       <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_sub_q   <= 1'b0;
`ifdef MPACC_CONDSUB_EN
      m_q         <= '0;
      dif_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      cin_q       <= cin_d;
      x_q         <= x_d;
      y_q         <= y_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_sub_q   <= res_sub_d;
`ifdef MPACC_CONDSUB_EN
      m_q         <= m_d;
      dif_q       <= dif_d;
`endif
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign acc_lsb   = s_q[0] ^ c_q[0];
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_sub   = res_sub_q;

endmodule
`default_nettype wire

// File: tb/tb_mp_csa_accum.sv
`default_nettype none
// ============================================================================
// tb_mp_csa_accum : randomized bench for mp_csa_accum (514/103 and 16/5 builds)
// Rev 1.0
// ============================================================================
module tb_mp_csa_accum;
  import mpacc_pkg::*;

  localparam int WB = 514;
  localparam int CB = 103;
  localparam int WS = 16;
  localparam int CS = 5;
  localparam int MW = WB + 2;
`ifdef MPACC_CONDSUB_EN
  localparam bit CONDSUB = 1'b1;
`else
  localparam bit CONDSUB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          res_ready = 1'b0;
  logic          sel = 1'b0;
  logic [1:0]    cmd_op = 2'd0;
  logic [WB-1:0] in_a = '0;
  logic [WB-1:0] modulus = '0;

  logic          b_ready, b_lsb, b_valid, b_sub, b_busy;
  logic [WB-1:0] b_data;
  logic          s_ready, s_lsb, s_valid, s_sub, s_busy;
  logic [WS-1:0] s_data;

  logic          o_ready, o_lsb, o_valid, o_sub, o_busy;
  logic [WB-1:0] o_data;

  int n_total = 0;
  int n_bad   = 0;

  logic [MW-1:0] mv [2];
  bit   [1:0]    ex;

  always #5 clk = ~clk;

  mp_csa_accum #(.WIDTH(WB), .CHUNK(CB)) u_big (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid & ~sel),
    .cmd_ready (b_ready),
    .cmd_op    (cmd_op),
    .in_a      (in_a),
    .modulus   (modulus),
    .acc_lsb   (b_lsb),
    .res_valid (b_valid),
    .res_ready (res_ready),
    .res_data  (b_data),
    .res_sub   (b_sub),
    .busy      (b_busy)
  );

  mp_csa_accum #(.WIDTH(WS), .CHUNK(CS)) u_small (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid & sel),
    .cmd_ready (s_ready),
    .cmd_op    (cmd_op),
    .in_a      (in_a[WS-1:0]),
    .modulus   (modulus[WS-1:0]),
    .acc_lsb   (s_lsb),
    .res_valid (s_valid),
    .res_ready (res_ready),
    .res_data  (s_data),
    .res_sub   (s_sub),
    .busy      (s_busy)
  );

  always_comb begin
    if (sel) begin
      o_ready = s_ready; o_lsb = s_lsb; o_valid = s_valid;
      o_sub   = s_sub;   o_busy = s_busy; o_data = WB'(s_data);
    end else begin
      o_ready = b_ready; o_lsb = b_lsb; o_valid = b_valid;
      o_sub   = b_sub;   o_busy = b_busy; o_data = b_data;
    end
  end

  task automatic check_eq(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (w=%0d): got=%0h expected=%0h", tag, sel ? WS : WB, got, exp);
    end
  endtask

  function automatic int idx();
    return sel ? 1 : 0;
  endfunction

  function automatic logic [MW-1:0] cur_mask();
    logic [MW-1:0] one;
    one = MW'(1);
    return (one << (sel ? WS : WB)) - one;
  endfunction

  function automatic int exp_lat();
    int n;
    n = sel ? nchunk(WS, CS) : nchunk(WB, CB);
    return CONDSUB ? (2 * n + 1) : (n + 1);
  endfunction

  function automatic logic [MW-1:0] rand_wide();
    logic [MW-1:0] r;
    r = '0;
    for (int i = 0; i < 17; i++) r = (r << 32) | MW'($urandom);
    return r;
  endfunction

  task automatic check_idle_reset(input string tag);
    check_eq({tag, "_ready"}, MW'(o_ready), MW'(1));
    check_eq({tag, "_valid"}, MW'(o_valid), MW'(0));
    check_eq({tag, "_busy"},  MW'(o_busy),  MW'(0));
    check_eq({tag, "_lsb"},   MW'(o_lsb),   MW'(0));
    check_eq({tag, "_data"},  MW'(o_data),  MW'(0));
    check_eq({tag, "_sub"},   MW'(o_sub),   MW'(0));
  endtask

  task automatic drive_cmd(input logic [1:0] op, input logic [WB-1:0] a, input logic [WB-1:0] m);
    @(negedge clk);
    check_eq("cmd_ready_idle", MW'(o_ready), MW'(1));
    cmd_op    = op;
    in_a      = a;
    modulus   = m;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic do_clear();
    drive_cmd(OP_CLEAR, '0, '0);
    mv[idx()] = '0;
    ex[idx()] = 1'b1;
    check_eq("clear_lsb", MW'(o_lsb), MW'(0));
  endtask

  task automatic do_acc(input logic [MW-1:0] a_in);
    logic [MW-1:0] a, s;
    a = a_in & cur_mask();
    drive_cmd(OP_ACC, a[WB-1:0], '0);
    s = mv[idx()] + a;
    if (s > cur_mask()) ex[idx()] = 1'b0;
    mv[idx()] = s & cur_mask();
    check_eq("acc_lsb", MW'(o_lsb), MW'(mv[idx()][0]));
  endtask

  function automatic bit shift_ok(input logic [MW-1:0] a);
    logic [MW-1:0] half;
    half = (cur_mask() >> 1) + MW'(1);
    return ex[idx()] && (mv[idx()] < half) && (a < half);
  endfunction

  task automatic do_shift(input logic [MW-1:0] a);
    drive_cmd(OP_ACC_SHIFT, a[WB-1:0], '0);
    mv[idx()] = (mv[idx()] + a) >> 1;
    check_eq("shift_lsb", MW'(o_lsb), MW'(mv[idx()][0]));
  endtask

  task automatic do_resolve(input logic [MW-1:0] m_in, input int hold);
    logic [MW-1:0] m, r, d;
    logic          sb;
    int            n;
    bit            seen;
    m = m_in & cur_mask();
    r = mv[idx()];
    if (CONDSUB && (r >= m)) begin
      d = r - m; sb = 1'b1;
    end else begin
      d = r; sb = 1'b0;
    end
    drive_cmd(OP_RESOLVE, '0, m[WB-1:0]);
    check_eq("busy_after_accept", MW'(o_busy), MW'(1));
    n = 0;
    seen = 1'b0;
    while (!seen && n < 64) begin
      @(posedge clk);
      n++;
      #1 seen = o_valid;
    end
    check_eq("latency", MW'(n), MW'(exp_lat()));
    check_eq("res_data", MW'(o_data), d);
    check_eq("res_sub", MW'(o_sub), MW'(sb));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      cmd_valid = (i % 2 == 0);
      cmd_op    = OP_CLEAR;
      @(posedge clk);
      #1;
      check_eq("hold_valid", MW'(o_valid), MW'(1));
      check_eq("hold_data",  MW'(o_data),  d);
      check_eq("hold_sub",   MW'(o_sub),   MW'(sb));
      check_eq("hold_ready", MW'(o_ready), MW'(0));
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    check_eq("hs_valid", MW'(o_valid), MW'(0));
    check_eq("hs_ready", MW'(o_ready), MW'(1));
    mv[idx()] = d;
    ex[idx()] = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [MW-1:0] a, m;
    mv[0] = '0; mv[1] = '0; ex = 2'b11;

    repeat (3) @(posedge clk);
    #1;
    sel = 1'b0; #1 check_idle_reset("rst_big");
    sel = 1'b1; #1 check_idle_reset("rst_small");
    sel = 1'b0;
    @(negedge clk) resetn = 1'b1;

    // Basic resolve and write-back
    do_clear(); do_acc(5); do_acc(7);
    do_resolve(20, 0);
    do_resolve(20, 0);
    // Conditional subtract, including equality
    do_clear(); do_acc(25); do_resolve(20, 0);
    do_clear(); do_acc(25); do_resolve(25, 0);
    do_clear(); do_acc(24); do_resolve(25, 0);
    // Shift path and lsb
    do_clear(); do_acc(6); do_shift(4); do_resolve(cur_mask(), 0);
    do_clear(); do_acc(3);
    // Backpressure with ignored commands, then write-back confirms nothing changed
    do_clear(); do_acc(9); do_resolve(20, 10); do_resolve(20, 0);

    // Reset in the middle of the add phase
    do_clear(); do_acc(77);
    drive_cmd(OP_RESOLVE, '0, WB'(20));
    @(posedge clk);
    #1 resetn = 1'b0;
    #1 check_idle_reset("rst_mid_add");
    @(posedge clk);
    #1 check_eq("rst_mid_valid", MW'(o_valid), MW'(0));
    @(negedge clk) resetn = 1'b1;
    mv[0] = '0; mv[1] = '0; ex = 2'b11;

    // Narrow build: slice-boundary carry and wrap-around
    sel = 1'b1;
    do_clear(); do_acc(16'h001F); do_acc(16'h0001); do_resolve(16'hFFFF, 0);
    do_clear(); do_acc(16'hFFFF); do_acc(16'hFFFF); do_resolve(16'hFFFF, 0);

    // Randomized traffic on both builds
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      do_clear();
      for (int it = 0; it < 40; it++) begin
        case ($urandom % 8)
          0: do_clear();
          1, 2, 3: begin
            a = ($urandom % 2 == 0) ? rand_wide() : MW'($urandom_range(0, 255));
            do_acc(a);
          end
          4, 5: begin
            a = MW'($urandom_range(0, 1000));
            if (shift_ok(a)) do_shift(a);
            else do_acc(a);
          end
          default: begin
            case ($urandom % 4)
              0: m = mv[idx()];
              1: m = mv[idx()] + MW'(1);
              2: m = mv[idx()] - MW'($urandom_range(0, 50));
              default: m = rand_wide();
            endcase
            do_resolve(m, int'($urandom % 4));
          end
        endcase
      end
      do_resolve(cur_mask(), 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
